// File: rtl/branch_div_ctrl_pkg.sv
// Shared encodings and defaults for the branch divergence controller.
// N_CORES comes from the `N_CORES macro; it falls back to 4 when the macro is not defined.
`ifndef N_CORES
`define N_CORES 4
`endif

package branch_div_ctrl_pkg;
    localparam int N_CORES_DEF   = `N_CORES;
    localparam int PC_W_DEF      = 8;
    localparam int MAX_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_IF    = 2'd1,
        OP_ELSE  = 2'd2,
        OP_ENDIF = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_EVAL = 2'd2
    } state_e;
endpackage

// File: rtl/branch_div_ctrl_depth_counter.sv
// Nesting depth counter (0..MAX) with full/empty flags.
// These flags drive the controller's overflow and underflow decisions.
module depth_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !full_o)
            count_d = count_q + W'(1);
        else if (dec_i && !empty_o)
            count_d = count_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
    assign full_o  = (count_q == W'(MAX));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/branch_div_ctrl.sv
// Divergence controller: turns IF/ELSE/ENDIF into predicate-stack pulses and skip redirects.
// Optional macro DIV_STATS_EN adds a saturating divergent-branch counter output div_count.
module branch_div_ctrl
    import branch_div_ctrl_pkg::*;
#(
    parameter int N_CORES   = N_CORES_DEF,
    parameter int PC_W      = PC_W_DEF,
    parameter int MAX_DEPTH = MAX_DEPTH_DEF,
    localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [1:0]         op,
    input  logic [N_CORES-1:0] cond,
    input  logic [PC_W-1:0]    target_pc,
    input  logic [N_CORES-1:0] ps_q,
    input  logic               ps_all_true,
    input  logic               ps_all_false,
    output logic [N_CORES-1:0] ps_d,
    output logic               ps_push,
    output logic               ps_pop,
    output logic               ps_comp,
    output logic               stall,
    output logic               pc_redirect_valid,
    output logic [PC_W-1:0]    pc_redirect,
    output logic [N_CORES-1:0] active_mask,
    output logic [DEPTH_W-1:0] depth,
    output logic               err,
    output state_e             dbg_state
`ifdef DIV_STATS_EN
    ,
    output logic [15:0]        div_count
`endif
);
    // Handshake: an op is taken when instr_valid=1, op!=NONE and stall=0 at the clock edge;
    // there is no ready return, the upstream must hold or drop the op while stall=1.

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [PC_W-1:0]    tgt_q, tgt_d;
    logic [N_CORES-1:0] psd_q, psd_d;
    logic               push_q, push_d, comp_q, comp_d, pop_q, pop_d;
    logic               rv_q, rv_d;
    logic [PC_W-1:0]    rpc_q, rpc_d;
    logic               err_q, err_d;
    logic [15:0]        div_q, div_d;

    logic               d_full, d_empty;
    logic [DEPTH_W-1:0] d_count;
    logic               accept, illegal;

    depth_counter #(.MAX(MAX_DEPTH), .W(DEPTH_W)) u_depth (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (state_q == ST_OP && op_q == OP_IF),
        .dec_i   (state_q == ST_OP && op_q == OP_ENDIF),
        .count_o (d_count),
        .full_o  (d_full),
        .empty_o (d_empty)
    );

    assign accept  = (state_q == ST_IDLE) && instr_valid && (op != OP_NONE);
    assign illegal = ((op == OP_IF) && d_full) ||
                     ((op == OP_ELSE || op == OP_ENDIF) && d_empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NONE;
            tgt_q   <= '0;
            psd_q   <= '0;
            push_q  <= 1'b0;
            comp_q  <= 1'b0;
            pop_q   <= 1'b0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
            err_q   <= 1'b0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            psd_q   <= psd_d;
            push_q  <= push_d;
            comp_q  <= comp_d;
            pop_q   <= pop_d;
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
            err_q   <= err_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tgt_d   = tgt_q;
        psd_d   = psd_q;
        push_d  = 1'b0;
        comp_d  = 1'b0;
        pop_d   = 1'b0;
        rv_d    = 1'b0;
        rpc_d   = rpc_q;
        err_d   = err_q;
        div_d   = div_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && illegal) begin
                    err_d = 1'b1;
                end else if (accept) begin
                    state_d = ST_OP;
                    op_d    = op_e'(op);
                    tgt_d   = target_pc;
                    push_d  = (op == OP_IF);
                    comp_d  = (op == OP_ELSE);
                    pop_d   = (op == OP_ENDIF);
                    if (op == OP_IF)
                        psd_d = cond & active_mask;
                end
            end
            ST_OP: state_d = ST_EVAL;
            ST_EVAL: begin
                state_d = ST_IDLE;
                // Flags already reflect the post-op top here; nobody runs the body, so skip it.
                if (op_q != OP_ENDIF && ps_all_false) begin
                    rv_d  = 1'b1;
                    rpc_d = tgt_q;
                end
                if (op_q == OP_IF && !ps_all_true && !ps_all_false && div_q != 16'hFFFF)
                    div_d = div_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall             = (state_q != ST_IDLE);
        ps_d              = psd_q;
        ps_push           = push_q;
        ps_comp           = comp_q;
        ps_pop            = pop_q;
        pc_redirect_valid = rv_q;
        pc_redirect       = rpc_q;
        depth             = d_count;
        err               = err_q;
        active_mask       = d_empty ? '1 : ps_q;
        dbg_state         = state_q;
    end

`ifdef DIV_STATS_EN
    assign div_count = div_q;
`else
    logic unused_div;
    assign unused_div = ^div_q;
`endif
endmodule

// File: tb/tb_branch_div_ctrl.sv
// Bench for branch_div_ctrl with a behavioural predicate stack attached to its stack ports.
// Build with +define+DIV_STATS_EN to also check div_count.
module tb_branch_div_ctrl;
    import branch_div_ctrl_pkg::*;

    localparam int N    = 4;
    localparam int MAXD = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         instr_valid = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [N-1:0] cond = '0;
    logic [7:0]   target_pc = '0;
    logic [N-1:0] ps_q, ps_d, active_mask;
    logic         ps_all_true, ps_all_false;
    logic         ps_push, ps_pop, ps_comp, stall, pc_redirect_valid, err;
    logic [7:0]   pc_redirect;
    logic [3:0]   depth;
    state_e       dbg_state;
`ifdef DIV_STATS_EN
    logic [15:0]  div_count;
`endif

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    branch_div_ctrl #(.N_CORES(N), .PC_W(8), .MAX_DEPTH(MAXD)) dut (
        .clk               (clk),
        .reset             (reset),
        .instr_valid       (instr_valid),
        .op                (op),
        .cond              (cond),
        .target_pc         (target_pc),
        .ps_q              (ps_q),
        .ps_all_true       (ps_all_true),
        .ps_all_false      (ps_all_false),
        .ps_d              (ps_d),
        .ps_push           (ps_push),
        .ps_pop            (ps_pop),
        .ps_comp           (ps_comp),
        .stall             (stall),
        .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect       (pc_redirect),
        .active_mask       (active_mask),
        .depth             (depth),
        .err               (err),
        .dbg_state         (dbg_state)
`ifdef DIV_STATS_EN
        ,
        .div_count         (div_count)
`endif
    );

    // Predicate stack: push writes a new top, comp sets top = parent & ~top, pop drops the top.
    logic [N-1:0] stk [0:MAXD];
    int           sp = 0;

    always @(posedge clk) begin
        if (reset) begin
            sp <= 0;
        end else if (ps_push && sp <= MAXD) begin
            stk[sp] <= ps_d;
            sp      <= sp + 1;
        end else if (ps_comp && sp > 0) begin
            stk[sp-1] <= ((sp > 1) ? stk[sp-2] : {N{1'b1}}) & ~stk[sp-1];
        end else if (ps_pop && sp > 0) begin
            sp <= sp - 1;
        end
    end

    always_comb begin
        ps_q         = (sp == 0) ? {N{1'b1}} : stk[sp-1];
        ps_all_true  = &ps_q;
        ps_all_false = ~|ps_q;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of lane masks, one entry per open IF, plus a countdown of busy cycles.
    logic [N-1:0] mstk[$];
    logic [N-1:0] pstk[$];
    logic [N-1:0] m_top, m_par, m_new;
    int           busy = 0;
    bit           started = 0;
    bit           pend_rd, pend_div;
    logic [7:0]   pend_tgt;
    bit           e_push, e_comp, e_pop, e_rv, e_err, e_stall;
    logic [7:0]   e_rpc;
    logic [N-1:0] e_psd, e_act;
    int           e_depth, e_div;

    always @(posedge clk) begin
        started = 1;
        e_push = 0; e_comp = 0; e_pop = 0; e_rv = 0;
        if (reset) begin
            busy = 0; mstk.delete(); e_err = 0; e_psd = '0; e_rpc = '0; e_div = 0;
        end else if (busy == 2) begin
            mstk = pstk;
            busy = 1;
        end else if (busy == 1) begin
            busy = 0;
            if (pend_rd) begin
                e_rv  = 1;
                e_rpc = pend_tgt;
            end
            if (pend_div && e_div < 65535)
                e_div++;
        end else if (instr_valid && op != 2'd0) begin
            m_top = (mstk.size() > 0) ? mstk[mstk.size()-1] : {N{1'b1}};
            m_par = (mstk.size() > 1) ? mstk[mstk.size()-2] : {N{1'b1}};
            if ((op == 2'd1 && mstk.size() == MAXD) || (op != 2'd1 && mstk.size() == 0)) begin
                e_err = 1;
            end else begin
                pstk = mstk;
                case (op)
                    2'd1: begin
                        pstk.push_back(cond & m_top);
                        e_push = 1;
                        e_psd  = cond & m_top;
                    end
                    2'd2: begin
                        pstk[pstk.size()-1] = m_par & ~m_top;
                        e_comp = 1;
                    end
                    default: begin
                        void'(pstk.pop_back());
                        e_pop = 1;
                    end
                endcase
                m_new    = (pstk.size() > 0) ? pstk[pstk.size()-1] : {N{1'b1}};
                pend_rd  = (op != 2'd3) && (m_new == '0);
                pend_div = (op == 2'd1) && (m_new != '0) && (m_new != {N{1'b1}});
                pend_tgt = target_pc;
                busy     = 2;
            end
        end
        e_stall = (busy != 0);
        e_depth = mstk.size();
        e_act   = (mstk.size() > 0) ? mstk[mstk.size()-1] : {N{1'b1}};
    end

    always @(negedge clk) begin
        if (started) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("ps_push", 32'(ps_push), 32'(e_push));
            chk("ps_comp", 32'(ps_comp), 32'(e_comp));
            chk("ps_pop", 32'(ps_pop), 32'(e_pop));
            chk("ps_d", 32'(ps_d), 32'(e_psd));
            chk("redirect_valid", 32'(pc_redirect_valid), 32'(e_rv));
            chk("redirect_pc", 32'(pc_redirect), 32'(e_rpc));
            chk("depth", 32'(depth), 32'(e_depth));
            chk("active_mask", 32'(active_mask), 32'(e_act));
            chk("err", 32'(err), 32'(e_err));
`ifdef DIV_STATS_EN
            chk("div_count", 32'(div_count), 32'(e_div));
`endif
        end
    end

    // Observations from the most recent issue() call.
    logic [2:0] obs_pulse;
    logic [N-1:0] obs_psd;
    int         obs_stall;
    logic       obs_rv;
    logic [7:0] obs_rpc;

    task automatic issue(input logic [1:0] o, input logic [N-1:0] c, input logic [7:0] t);
        @(posedge clk); #1;
        instr_valid = 1'b1; op = o; cond = c; target_pc = t;
        @(posedge clk); #1;
        instr_valid = 1'b0; op = 2'd0;
        obs_pulse = {ps_push, ps_comp, ps_pop};
        obs_psd   = ps_d;
        obs_stall = int'(stall);
        @(posedge clk); #1;
        obs_stall += int'(stall);
        @(posedge clk); #1;
        obs_stall += int'(stall);
        obs_rv  = pc_redirect_valid;
        obs_rpc = pc_redirect;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_depth", 32'(depth), 32'd0);
        chk("idle_mask", 32'(active_mask), 32'hF);
        chk("idle_err", 32'(err), 32'd0);

        issue(2'd1, 4'b1010, 8'h20);
        chk("if1010_pulse", 32'(obs_pulse), 32'b100);
        chk("if1010_psd", 32'(obs_psd), 32'b1010);
        chk("if1010_stall_cycles", 32'(obs_stall), 32'd2);
        chk("if1010_no_redirect", 32'(obs_rv), 32'd0);
        chk("if1010_depth", 32'(depth), 32'd1);
        chk("if1010_mask", 32'(active_mask), 32'b1010);
        issue(2'd3, 4'b0, 8'h0);

        issue(2'd1, 4'b0000, 8'h30);
        chk("if0000_psd", 32'(obs_psd), 32'd0);
        chk("if0000_redirect", 32'(obs_rv), 32'd1);
        chk("if0000_redirect_pc", 32'(obs_rpc), 32'h30);
        issue(2'd3, 4'b0, 8'h0);
        chk("endif_pulse", 32'(obs_pulse), 32'b001);
        chk("endif_no_redirect", 32'(obs_rv), 32'd0);
        chk("endif_depth", 32'(depth), 32'd0);

        issue(2'd1, 4'b1111, 8'h11);
        chk("if1111_no_redirect", 32'(obs_rv), 32'd0);
        issue(2'd2, 4'b0, 8'h40);
        chk("else_pulse", 32'(obs_pulse), 32'b010);
        chk("else_redirect", 32'(obs_rv), 32'd1);
        chk("else_redirect_pc", 32'(obs_rpc), 32'h40);
        chk("else_mask", 32'(active_mask), 32'b0000);
        issue(2'd3, 4'b0, 8'h0);
        chk("endif2_mask", 32'(active_mask), 32'hF);

        issue(2'd3, 4'b0, 8'h0);
        chk("underflow_pulse", 32'(obs_pulse), 32'd0);
        chk("underflow_stall", 32'(obs_stall), 32'd0);
        chk("underflow_err", 32'(err), 32'd1);

        for (int i = 0; i <= MAXD; i++) issue(2'd1, 4'b1111, 8'h50);
        chk("overflow_pulse", 32'(obs_pulse), 32'd0);
        chk("overflow_stall", 32'(obs_stall), 32'd0);
        chk("overflow_depth", 32'(depth), 32'(MAXD));
        for (int i = 0; i < MAXD; i++) issue(2'd3, 4'b0, 8'h0);
        chk("unwind_depth", 32'(depth), 32'd0);

        // Reset lands while the IF is in its pulse cycle.
        @(posedge clk); #1;
        instr_valid = 1'b1; op = 2'd1; cond = 4'b0000; target_pc = 8'h66;
        @(posedge clk); #1;
        instr_valid = 1'b0; op = 2'd0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midop_stall", 32'(stall), 32'd0);
        chk("midop_depth", 32'(depth), 32'd0);
        chk("midop_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        chk("midop_no_redirect", 32'(pc_redirect_valid), 32'd0);
        chk("midop_depth2", 32'(depth), 32'd0);

`ifdef DIV_STATS_EN
        issue(2'd1, 4'b0110, 8'h70);
        chk("div_count_one", 32'(div_count), 32'd1);
        issue(2'd3, 4'b0, 8'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset       = ($urandom_range(0, 399) == 0);
            instr_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = 2'd1;
                4, 5:       op = 2'd2;
                6, 7, 8:    op = 2'd3;
                default:    op = 2'd0;
            endcase
            case ($urandom_range(0, 3))
                0:       cond = 4'b0000;
                1:       cond = 4'b1111;
                default: cond = 4'($urandom_range(0, 15));
            endcase
            target_pc = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #1;
        reset = 1'b0; instr_valid = 1'b0; op = 2'd0;
        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
